// File: rtl/axi_write_pkg.sv
// Shared AXI4-Lite types for the peripheral's read and write slaves.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        COLLECT,
        ISSUE,
        WAIT_ACK,
        RESP
    } wr_state_t;

endpackage

// File: rtl/axi_write_if.sv
// AXI4-Lite write-side channels (AW, W, B) between interconnect and slave.
interface axi_write_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  AWREADY, WREADY, BRESP, BVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output AWREADY, WREADY, BRESP, BVALID
    );
endinterface

// File: rtl/axi_write.sv
// AXI4-Lite write slave: captures AW and W independently, issues a single
// back-end write pulse for aligned addresses, waits for completion and
// returns the B response. Misaligned addresses get SLVERR without a write.
module axi_write
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    axi_clk,
    input  logic                    rst_n,
    axi_write_if.slave              s_axi,
    output logic [ADDR_WIDTH-1:0]   addr_out,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [DATA_WIDTH/8-1:0] strb_out,
    output logic                    write_req,
    input  logic                    write_done
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB_W      = $clog2(STRB_WIDTH);

    wr_state_t               r_state,     w_state_nx;
    logic                    r_aw_done,   w_aw_done_nx;
    logic                    r_w_done,    w_w_done_nx;
    logic                    r_awready,   w_awready_nx;
    logic                    r_wready,    w_wready_nx;
    logic                    r_bvalid,    w_bvalid_nx;
    resp_t                   r_bresp,     w_bresp_nx;
    logic                    r_write_req, w_write_req_nx;
    logic [ADDR_WIDTH-1:0]   r_addr,      w_addr_nx;
    logic [DATA_WIDTH-1:0]   r_data,      w_data_nx;
    logic [STRB_WIDTH-1:0]   r_strb,      w_strb_nx;
    logic                    w_aw_hs;
    logic                    w_w_hs;

    assign w_aw_hs = s_axi.AWVALID && r_awready;
    assign w_w_hs  = s_axi.WVALID  && r_wready;

    // State register and registered outputs; reset discards any pending write.
    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= COLLECT;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= OKAY;
            r_write_req <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_strb      <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_aw_done   <= w_aw_done_nx;
            r_w_done    <= w_w_done_nx;
            r_awready   <= w_awready_nx;
            r_wready    <= w_wready_nx;
            r_bvalid    <= w_bvalid_nx;
            r_bresp     <= w_bresp_nx;
            r_write_req <= w_write_req_nx;
            r_addr      <= w_addr_nx;
            r_data      <= w_data_nx;
            r_strb      <= w_strb_nx;
        end
    end

    // Next-state and next-output logic for the capture/issue/ack/response flow.
    always_comb begin
        w_state_nx     = r_state;
        w_aw_done_nx   = r_aw_done;
        w_w_done_nx    = r_w_done;
        w_bvalid_nx    = r_bvalid;
        w_bresp_nx     = r_bresp;
        w_write_req_nx = 1'b0;
        w_addr_nx      = r_addr;
        w_data_nx      = r_data;
        w_strb_nx      = r_strb;

        case (r_state)
            COLLECT: begin
                if (w_aw_hs) begin
                    w_aw_done_nx = 1'b1;
                    w_addr_nx    = s_axi.AWADDR;
                end
                if (w_w_hs) begin
                    w_w_done_nx = 1'b1;
                    w_data_nx   = s_axi.WDATA;
                    w_strb_nx   = s_axi.WSTRB;
                end
                // Alignment is judged on the address as it will be latched,
                // so a same-cycle AW capture is seen here too.
                if (w_aw_done_nx && w_w_done_nx) begin
                    if (w_addr_nx[LSB_W-1:0] != '0) begin
                        w_state_nx  = RESP;
                        w_bvalid_nx = 1'b1;
                        w_bresp_nx  = SLVERR;
                    end else begin
                        w_state_nx     = ISSUE;
                        w_write_req_nx = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (write_done) begin
                    w_state_nx  = RESP;
                    w_bvalid_nx = 1'b1;
                    w_bresp_nx  = OKAY;
                end else begin
                    w_state_nx = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (write_done) begin
                    w_state_nx  = RESP;
                    w_bvalid_nx = 1'b1;
                    w_bresp_nx  = OKAY;
                end
            end
            RESP: begin
                if (s_axi.BREADY) begin
                    w_state_nx   = COLLECT;
                    w_bvalid_nx  = 1'b0;
                    w_aw_done_nx = 1'b0;
                    w_w_done_nx  = 1'b0;
                end
            end
            default: begin
                w_state_nx = COLLECT;
            end
        endcase

        w_awready_nx = (w_state_nx == COLLECT) && !w_aw_done_nx;
        w_wready_nx  = (w_state_nx == COLLECT) && !w_w_done_nx;
    end

    assign s_axi.AWREADY = r_awready;
    assign s_axi.WREADY  = r_wready;
    assign s_axi.BVALID  = r_bvalid;
    assign s_axi.BRESP   = r_bresp;
    assign write_req     = r_write_req;
    assign addr_out      = r_addr;
    assign data_out      = r_data;
    assign strb_out      = r_strb;

endmodule
